// File: rtl/hilo_pipe.sv
// hilo_pipe
//   Carries HI/LO write requests from the execute stage through the MEM and
//   WB pipeline registers. Each request is then committed to the
//   architectural HI/LO registers. The MEM copy, the WB copy and the committed
//   values are all exposed for execute-stage forwarding.
//
//   Optional feature: define HILO_PIPE_FLUSH_EN to add a 'flush' input.
//   A flush clears the MEM and WB registers. The commit of the pre-edge WB
//   entry still happens on the flushing edge.
//
// Ports
//   clk          pipeline clock
//   rst          asynchronous active-high reset
//   stall        per-stage stall vector (0=pc,1=if,2=id,3=ex,4=mem,5=wb)
//   flush        (HILO_PIPE_FLUSH_EN only) clear the MEM/WB registers
//   ex_hi_i      HI value requested by the EX instruction
//   ex_lo_i      LO value requested by the EX instruction
//   ex_whilo_i   EX instruction writes HI/LO
//   mem_hi_o     HI request held in MEM
//   mem_lo_o     LO request held in MEM
//   mem_whilo_o  MEM request valid
//   wb_hi_o      HI request held in WB
//   wb_lo_o      LO request held in WB
//   wb_whilo_o   WB request valid
//   hi_o         committed HI
//   lo_o         committed LO
module hilo_pipe #(
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
`ifdef HILO_PIPE_FLUSH_EN
  input  logic               flush,
`endif
  input  logic [DATA_W-1:0]  ex_hi_i,
  input  logic [DATA_W-1:0]  ex_lo_i,
  input  logic               ex_whilo_i,
  output logic [DATA_W-1:0]  mem_hi_o,
  output logic [DATA_W-1:0]  mem_lo_o,
  output logic               mem_whilo_o,
  output logic [DATA_W-1:0]  wb_hi_o,
  output logic [DATA_W-1:0]  wb_lo_o,
  output logic               wb_whilo_o,
  output logic [DATA_W-1:0]  hi_o,
  output logic [DATA_W-1:0]  lo_o
);

  logic [DATA_W-1:0] mem_hi_q, mem_hi_d;
  logic [DATA_W-1:0] mem_lo_q, mem_lo_d;
  logic              mem_whilo_q, mem_whilo_d;
  logic [DATA_W-1:0] wb_hi_q, wb_hi_d;
  logic [DATA_W-1:0] wb_lo_q, wb_lo_d;
  logic              wb_whilo_q, wb_whilo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              flush_w;

`ifdef HILO_PIPE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // EX -> MEM stage boundary
  always_comb begin
    mem_hi_d    = mem_hi_q;
    mem_lo_d    = mem_lo_q;
    mem_whilo_d = mem_whilo_q;
    if (flush_w) begin
      mem_hi_d    = '0;
      mem_lo_d    = '0;
      mem_whilo_d = 1'b0;
    end else if (!stall[3]) begin
      mem_hi_d    = ex_hi_i;
      mem_lo_d    = ex_lo_i;
      mem_whilo_d = ex_whilo_i;
    end else if (!stall[4]) begin
      // EX is stuck but MEM moves on: MEM must not re-issue its old entry.
      mem_hi_d    = '0;
      mem_lo_d    = '0;
      mem_whilo_d = 1'b0;
    end
  end

  // MEM -> WB stage boundary
  always_comb begin
    wb_hi_d    = wb_hi_q;
    wb_lo_d    = wb_lo_q;
    wb_whilo_d = wb_whilo_q;
    if (flush_w) begin
      wb_hi_d    = '0;
      wb_lo_d    = '0;
      wb_whilo_d = 1'b0;
    end else if (!stall[4]) begin
      wb_hi_d    = mem_hi_q;
      wb_lo_d    = mem_lo_q;
      wb_whilo_d = mem_whilo_q;
    end else if (!stall[5]) begin
      wb_hi_d    = '0;
      wb_lo_d    = '0;
      wb_whilo_d = 1'b0;
    end
  end

  // WB -> architectural commit. This is not gated by stall or flush. A held
  // WB entry rewrites the same value. The WB entry is older than any flushing
  // instruction.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wb_whilo_q) begin
      hi_d = wb_hi_q;
      lo_d = wb_lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_hi_q    <= '0;
      mem_lo_q    <= '0;
      mem_whilo_q <= 1'b0;
      wb_hi_q     <= '0;
      wb_lo_q     <= '0;
      wb_whilo_q  <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      mem_hi_q    <= mem_hi_d;
      mem_lo_q    <= mem_lo_d;
      mem_whilo_q <= mem_whilo_d;
      wb_hi_q     <= wb_hi_d;
      wb_lo_q     <= wb_lo_d;
      wb_whilo_q  <= wb_whilo_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign mem_hi_o    = mem_hi_q;
  assign mem_lo_o    = mem_lo_q;
  assign mem_whilo_o = mem_whilo_q;
  assign wb_hi_o     = wb_hi_q;
  assign wb_lo_o     = wb_lo_q;
  assign wb_whilo_o  = wb_whilo_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

// File: tb/tb_hilo_pipe.sv
// Testbench for hilo_pipe: a reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_hilo_pipe;
  localparam int DATA_W  = 32;
  localparam int STALL_W = 6;

  logic              clk;
  logic              rst;
  logic [STALL_W-1:0] stall;
  logic [DATA_W-1:0] ex_hi_i, ex_lo_i;
  logic              ex_whilo_i;
  logic [DATA_W-1:0] mem_hi_o, mem_lo_o, wb_hi_o, wb_lo_o, hi_o, lo_o;
  logic              mem_whilo_o, wb_whilo_o;
  logic              flush;

  int n_pass = 0;
  int n_chk  = 0;

  hilo_pipe #(.DATA_W(DATA_W), .STALL_W(STALL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
`ifdef HILO_PIPE_FLUSH_EN
    .flush      (flush),
`endif
    .ex_hi_i    (ex_hi_i),
    .ex_lo_i    (ex_lo_i),
    .ex_whilo_i (ex_whilo_i),
    .mem_hi_o   (mem_hi_o),
    .mem_lo_o   (mem_lo_o),
    .mem_whilo_o(mem_whilo_o),
    .wb_hi_o    (wb_hi_o),
    .wb_lo_o    (wb_lo_o),
    .wb_whilo_o (wb_whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Behavioural model. A pipeline slot is {valid, hi, lo}. The model works
  // per slot with two rules. A slot takes its producer's entry when the
  // producer advances. A slot is emptied when its producer is stuck but the
  // slot itself is free. The architectural registers take the WB slot
  // whenever it is valid.
  typedef struct {
    logic              v;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } slot_t;

  slot_t m_slot[3];              // 0 = EX view (inputs), 1 = MEM, 2 = WB
  logic [DATA_W-1:0] m_hi, m_lo;
  slot_t empty_s;
  logic  flush_eff;

`ifdef HILO_PIPE_FLUSH_EN
  assign flush_eff = flush;
`else
  assign flush_eff = 1'b0;
`endif

  initial begin
    empty_s.v = 1'b0; empty_s.hi = '0; empty_s.lo = '0;
  end

  always @(posedge clk or posedge rst) begin
    slot_t nxt[3];
    if (rst) begin
      m_slot[1] = empty_s; m_slot[2] = empty_s;
      m_hi = '0; m_lo = '0;
    end else begin
      m_slot[0].v = ex_whilo_i; m_slot[0].hi = ex_hi_i; m_slot[0].lo = ex_lo_i;
      if (m_slot[2].v) begin m_hi = m_slot[2].hi; m_lo = m_slot[2].lo; end
      for (int s = 1; s <= 2; s++) begin
        // the slot's producer is stage s+2 in the stall vector numbering
        if (flush_eff)            nxt[s] = empty_s;
        else if (!stall[s + 2])   nxt[s] = m_slot[s - 1];
        else if (!stall[s + 3])   nxt[s] = empty_s;
        else                      nxt[s] = m_slot[s];
      end
      m_slot[1] = nxt[1]; m_slot[2] = nxt[2];
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mem_whilo", {31'd0, mem_whilo_o}, {31'd0, m_slot[1].v});
      chk("mem_hi", mem_hi_o, m_slot[1].hi);
      chk("mem_lo", mem_lo_o, m_slot[1].lo);
      chk("wb_whilo", {31'd0, wb_whilo_o}, {31'd0, m_slot[2].v});
      chk("wb_hi", wb_hi_o, m_slot[2].hi);
      chk("wb_lo", wb_lo_o, m_slot[2].lo);
      chk("hi", hi_o, m_hi);
      chk("lo", lo_o, m_lo);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] h, input logic [31:0] l);
    ex_whilo_i = w; ex_hi_i = h; ex_lo_i = l;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_mem_w"}, {31'd0, mem_whilo_o}, 32'd0);
    chk({tag, "_mem_hi"}, mem_hi_o, 32'd0);
    chk({tag, "_wb_w"}, {31'd0, wb_whilo_o}, 32'd0);
    chk({tag, "_wb_lo"}, wb_lo_o, 32'd0);
    chk({tag, "_hi"}, hi_o, 32'd0);
    chk({tag, "_lo"}, lo_o, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    #22;
    rst = 1'b0;
    cmp_en = 1'b1;
    step(); step();
    all_zero("post_rst");

    // Single write: committed two edges after the MEM capture
    drive(1'b1, 32'h12345678, 32'h9ABCDEF0);
    step();                                    // edge N
    drive(1'b0, 32'd0, 32'd0);
    chk("sw_mem_w", {31'd0, mem_whilo_o}, 32'd1);
    chk("sw_mem_hi", mem_hi_o, 32'h12345678);
    step();                                    // N+1
    chk("sw_wb_w", {31'd0, wb_whilo_o}, 32'd1);
    chk("sw_wb_lo", wb_lo_o, 32'h9ABCDEF0);
    chk("sw_hi_pre", hi_o, 32'd0);
    step();                                    // N+2
    chk("sw_hi", hi_o, 32'h12345678);
    chk("sw_lo", lo_o, 32'h9ABCDEF0);

    // Async reset between edges clears outputs before the next edge
    #3 rst = 1'b1;
    #1 all_zero("async_rst");
    step();
    rst = 1'b0;
    step();
    all_zero("rst_rel");

    // Back-to-back
    drive(1'b1, 32'd1, 32'd0); step();         // N
    drive(1'b1, 32'd2, 32'd0); step();         // N+1
    drive(1'b0, 32'd0, 32'd0);
    chk("bb_mem_w", {31'd0, mem_whilo_o}, 32'd1);
    chk("bb_wb_w", {31'd0, wb_whilo_o}, 32'd1);
    step();                                    // N+2
    chk("bb_hi1", hi_o, 32'd1);
    chk("bb_wb_w2", {31'd0, wb_whilo_o}, 32'd1);
    step();                                    // N+3
    chk("bb_hi2", hi_o, 32'd2);

    // EX stall bubble
    drive(1'b1, 32'h0000000A, 32'h0000000B);
    stall = 6'b001111;
    step();
    chk("exs_mem_w0", {31'd0, mem_whilo_o}, 32'd0);
    step();
    chk("exs_mem_w1", {31'd0, mem_whilo_o}, 32'd0);
    chk("exs_hi_hold", hi_o, 32'd2);
    stall = 6'b000000;
    step();
    drive(1'b0, 32'd0, 32'd0);
    chk("exs_mem_hi", mem_hi_o, 32'h0000000A);
    chk("exs_mem_w2", {31'd0, mem_whilo_o}, 32'd1);
    step();
    chk("exs_hi_wait", hi_o, 32'd2);
    step();
    chk("exs_hi", hi_o, 32'h0000000A);

    // Full hold: B in WB, C in MEM
    drive(1'b1, 32'h0000000B, 32'h0000000B); step();
    drive(1'b1, 32'h0000000C, 32'h0000000C); step();
    drive(1'b0, 32'd0, 32'd0);
    stall = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fh_mem_hi", mem_hi_o, 32'h0000000C);
      chk("fh_wb_hi", wb_hi_o, 32'h0000000B);
      chk("fh_hi", hi_o, 32'h0000000B);
    end
    stall = 6'b000000;
    step();
    chk("fh_wb_rel", wb_hi_o, 32'h0000000C);
    step();
    chk("fh_hi_rel", hi_o, 32'h0000000C);

`ifdef HILO_PIPE_FLUSH_EN
    drive(1'b1, 32'h00000111, 32'h00000111); step();
    drive(1'b1, 32'h00000222, 32'h00000222); step();
    drive(1'b0, 32'd0, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_hi", hi_o, 32'h00000111);
    chk("fl_mem_w", {31'd0, mem_whilo_o}, 32'd0);
    chk("fl_wb_w", {31'd0, wb_whilo_o}, 32'd0);
    step(); step();
    chk("fl_hi_keep", hi_o, 32'h00000111);
`endif

    // Randomized traffic with random stalls and occasional mid-flight reset
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 1) == 1, $urandom, $urandom);
      stall = ($urandom_range(0, 2) == 0) ? STALL_W'($urandom) : '0;
`ifdef HILO_PIPE_FLUSH_EN
      flush = ($urandom_range(0, 30) == 0);
`endif
      if ($urandom_range(0, 150) == 0) begin
        #2 rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hilo_pipe.md
Name: hilo_pipe

Overview:
- Downstream end of the HI/LO write-request interface driven by the execute stage.
- Carries each HI/LO write request through the MEM and WB pipeline stages, then commits it to the architectural HI/LO registers.
- Exposes the in-flight MEM-stage and WB-stage copies, and the committed values, for execute-stage forwarding.
- Replaces separate ex/mem, mem/wb and hilo_reg handling of HI/LO with one stall-aware block.

Parameters:
- DATA_W, 32, width of HI and LO.
- STALL_W, 6, width of the pipeline stall vector. Bit 0 = pc, 1 = if, 2 = id, 3 = ex, 4 = mem, 5 = wb.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  STALL_W  per-stage stall; 1 = stage holds.
- ex_hi_i  in  DATA_W  HI value requested by the instruction in EX.
- ex_lo_i  in  DATA_W  LO value requested by the instruction in EX.
- ex_whilo_i  in  1  EX instruction writes HI/LO.
- mem_hi_o  out  DATA_W  HI request held in the MEM stage.
- mem_lo_o  out  DATA_W  LO request held in the MEM stage.
- mem_whilo_o  out  1  MEM-stage request valid.
- wb_hi_o  out  DATA_W  HI request held in the WB stage.
- wb_lo_o  out  DATA_W  LO request held in the WB stage.
- wb_whilo_o  out  1  WB-stage request valid.
- hi_o  out  DATA_W  committed HI.
- lo_o  out  DATA_W  committed LO.

Behaviour:
- Reset (async, rst=1): every output goes to 0 immediately and holds at 0 while rst=1. The first capture happens on the first rising clk edge after rst falls.
- EX->MEM register, evaluated at each rising edge:
  - stall[3]=1 and stall[4]=0: insert a bubble (mem_whilo_o=0, mem_hi_o=0, mem_lo_o=0).
  - stall[3]=0: capture ex_hi_i, ex_lo_i and ex_whilo_i.
  - otherwise (stall[3]=1, stall[4]=1): hold.
- MEM->WB register: same rules, using stall[4] (upstream) and stall[5] (downstream), sourced from the mem_* outputs.
- Commit: at each rising edge where wb_whilo_o=1, hi_o<=wb_hi_o and lo_o<=wb_lo_o. Otherwise hi_o and lo_o hold.
  - Commit is not gated by stall[5]. A held WB entry recommits the same values, which is idempotent.
- Latency: a request present at EX on edge N appears on mem_* after edge N. It appears on wb_* after edge N+1 and on hi_o/lo_o after edge N+2, assuming no stalls.
- Payload is passed unmodified; values are captured even when whilo=0. Consumers qualify every value with its whilo bit.
- Back-to-back requests on consecutive cycles all commit in program order; no request is dropped or merged.
- A stall covering EX and MEM (stall[4:3]=11) freezes both the MEM and WB registers only when stall[5]=1. With stall[5]=0, the WB register receives a bubble and the MEM register holds.
- Forwarding priority for consumers is MEM over WB over committed; this block only guarantees that the three views are mutually consistent within each cycle.
- rst asserted mid-flight discards all in-flight requests; none commits.
- No combinational path from any input to any output.

Optional Feature:
- Macro: HILO_PIPE_FLUSH_EN.
- Defined: adds input flush (1 bit). flush=1 at an edge clears the MEM and WB registers to 0 (whilo=0, payload=0). This takes priority over stall and capture.
  - The commit using the pre-edge WB contents still occurs on that same edge, because the WB instruction is older than the flushing instruction.
  - hi_o and lo_o are unaffected by flush.
- Undefined: no flush port. Behaviour is exactly as above.

Test Plan:
- Reset: rst=1 asynchronously between edges -> all outputs 0 before the next edge; after release with ex_whilo_i=0, all outputs remain 0.
- Single write, no stall: ex_hi_i=0x12345678, ex_lo_i=0x9ABCDEF0, ex_whilo_i=1 for one cycle (edge N) -> mem_* valid after edge N; wb_* valid after edge N+1; hi_o=0x12345678 and lo_o=0x9ABCDEF0 after edge N+2.
- Back-to-back writes: HI=1 then HI=2 (LO=0) on consecutive cycles -> hi_o=1 after edge N+2 and hi_o=2 after edge N+3; mem_whilo_o and wb_whilo_o stay 1 across the burst.
- EX stall bubble: request A in EX, stall=6'b001111 for 2 cycles, then released -> mem_whilo_o=0 during the stall; A enters MEM only after release; hi_o updates only after A reaches WB.
- Full hold: A in MEM, stall=6'b111111 for 3 cycles -> mem_* and wb_* unchanged; wb entry B recommits the same value each edge; hi_o stable at B.
- Flush (HILO_PIPE_FLUSH_EN): A in WB, B in MEM, flush=1 -> A commits on that edge; mem_whilo_o=0 and wb_whilo_o=0 afterwards; B never commits.
